fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage hart, upstream of decode. Owns the PC register,
//  drives the combinational imem port, selects next PC (sequential / predicted / redirect)
//  and holds the IF/ID pipeline register (valid, inst, pc, pc+4) feeding decode.
//  Accepts stall from the hazard unit, redirect from branch/jump resolution, halt from retire.
// PARAMETERS
//  RESET_ADDR  32'h00000000  PC value loaded on reset; first fetch address
// PORTS
//  i_clk             in   1   global clock
//  i_rst             in   1   synchronous active-high reset
//  o_imem_raddr      out  32  fetch address = PC (always 4-byte aligned)
//  i_imem_rdata      in   32  instruction word, valid same cycle
//  i_stall           in   1   hold PC and IF/ID (decode cannot accept)
//  i_redirect_valid  in   1   taken branch/jump or mispredict recovery from execute
//  i_redirect_pc     in   32  new PC when i_redirect_valid; bits[1:0] must be 00
//  i_halt            in   1   ebreak/trap retired; stop fetching until reset
//  o_if_valid        out  1   IF/ID holds a real instruction
//  o_if_inst         out  32  IF/ID instruction (NOP 32'h00000013 when invalid)
//  o_if_pc           out  32  IF/ID PC of the instruction
//  o_if_pc4          out  32  IF/ID PC+4
//  o_if_pred_taken   out  1   fetch predicted this branch taken (0 without FETCH_BTFN_EN)
// BEHAVIOUR
//  Reset: PC=RESET_ADDR, state=BOOT, o_if_valid=0, o_if_inst=32'h13, o_if_pc=0,
//   o_if_pc4=0, o_if_pred_taken=0. Reset mid-operation discards all state identically.
//  FSM: BOOT -> RUN after one cycle (BOOT fetches from PC but IF/ID stays invalid only if
//   stalled/redirected; otherwise BOOT behaves as RUN). RUN -> HALT on i_halt. HALT sticky
//   until i_rst: PC frozen, IF/ID cleared to invalid NOP, redirect/stall ignored.
//  Priority per rising edge (RUN/BOOT): halt > redirect > stall > advance.
//   redirect: PC<=i_redirect_pc; IF/ID flushed (valid=0, inst=NOP, pred=0); stall ignored.
//   stall:    PC and IF/ID unchanged; imem re-read at same PC.
//   advance:  IF/ID<={1,i_imem_rdata,PC,PC+4,pred}; PC<=next_pc.
//  next_pc = pred ? PC+B_imm : PC+4; 32-bit modular add, wraps at 2^32 with no flag.
//  Latency: instruction appears on o_if_* one cycle after its PC drives o_imem_raddr.
//  First valid IF/ID instruction: cycle after reset deasserts, pc=RESET_ADDR.
//  Redirect with i_redirect_pc[1:0]!=00 is an execute-stage trap; fetch forces bits[1:0]
//   to 00 when loading PC (never emits misaligned o_imem_raddr).
//  Redirect and stall same cycle: redirect wins, flush occurs. Halt and redirect same cycle:
//   halt wins, PC not updated.
// CONFIGURATION
//  FETCH_BTFN_EN defined: predecode i_imem_rdata; opcode 7'b1100011 with inst[31]=1
//   (backward branch) -> pred=1, next_pc=PC+sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
//   Execute compares actual outcome with o_if_pred_taken and redirects on mismatch.
//  Not defined: pred tied 0, next_pc always PC+4, predecode logic absent.
// STRUCTURE
//  hart_pkg: NOP_INST=32'h00000013, OPC_BRANCH=7'b1100011, fetch FSM enum {BOOT,RUN,HALT}.
//  One sub-module: fetch_predecode (B-imm extraction, backward-branch predict; combinational),
//   instantiated only under FETCH_BTFN_EN. PC reg, FSM and IF/ID reg live in fetch_stage.
// TESTING
//  Reset RESET_ADDR=32'h100, no stall 3 cycles -> raddr 100,104,108; o_if_pc 100,104 valid.
//  i_stall=1 two cycles at PC=0x108 -> raddr held 0x108, o_if_* unchanged, then resumes 0x10C.
//  Redirect to 0x200 with stall=1 same cycle -> next cycle raddr=0x200, o_if_valid=0, inst=0x13.
//  i_halt=1 at PC=0x40 -> o_if_valid=0 forever, raddr frozen 0x40; i_rst restores RESET_ADDR.
//  PC=32'hFFFFFFFC advance -> PC wraps to 0x00000000, o_if_pc4=0.
//  FETCH_BTFN_EN: inst 32'hFE000EE3 (beq x0,x0,-4) at 0x20 -> pred=1, next raddr=0x1C;
//   macro off -> pred=0, next raddr=0x24.

Source files
------------

// File: rtl/hart_pkg.sv
// Shared definitions for the hart pipeline: instruction constants, the fetch
// FSM encoding and the IF/ID pipeline register layout.
package hart_pkg;

  localparam logic [31:0] NOP_INST   = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred_taken;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    valid:      1'b0,
    inst:       NOP_INST,
    pc:         32'h0,
    pc4:        32'h0,
    pred_taken: 1'b0
  };

  // Fetch only ever issues word-aligned addresses.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode for static backward-taken/forward-not-taken prediction:
// spots conditional branches with a negative offset and extracts their B-immediate.
module fetch_predecode
  import hart_pkg::*;
(
  input  logic [31:0] inst,
  output logic        pred_taken,
  output logic [31:0] b_imm
);

  logic is_branch;

  assign is_branch  = (inst[6:0] == OPC_BRANCH);
  // Sign bit of the B-immediate doubles as the "backward" indicator.
  assign pred_taken = is_branch & inst[31];
  assign b_imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};

  // Register and funct3 fields play no part in the prediction.
  logic unused_fields;
  assign unused_fields = &{1'b0, inst[24:12]};

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch FSM and IF/ID register.
// Define FETCH_BTFN_EN to enable static backward-branch prediction in fetch.
module fetch_stage
  import hart_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_if_valid,
  output logic [31:0] o_if_inst,
  output logic [31:0] o_if_pc,
  output logic [31:0] o_if_pc4,
  output logic        o_if_pred_taken
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       if_q, if_d;

  logic [31:0]  seq_pc;
  logic [31:0]  next_pc;
  logic         pred_taken;

  assign seq_pc = pc_q + 32'd4;

`ifdef FETCH_BTFN_EN
  logic [31:0] b_imm;

  fetch_predecode u_predecode (
    .inst       (i_imem_rdata),
    .pred_taken (pred_taken),
    .b_imm      (b_imm)
  );

  // A 2-byte-aligned branch target is squashed to a word address here; execute
  // sees the mismatch against the real target and redirects.
  assign next_pc = align_word(pred_taken ? (pc_q + b_imm) : seq_pc);
`else
  assign pred_taken = 1'b0;
  assign next_pc    = seq_pc;
`endif

  // NOTE: every signal written below gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if_d    = if_q;

    case (state_q)
      BOOT, RUN: begin
        state_d = RUN;
        if (i_halt) begin
          state_d = HALT;
          if_d    = IF_ID_BUBBLE;
        end else if (i_redirect_valid) begin
          pc_d = align_word(i_redirect_pc);
          if_d = IF_ID_BUBBLE;
        end else if (!i_stall) begin
          pc_d = next_pc;
          if_d = '{
            valid:      1'b1,
            inst:       i_imem_rdata,
            pc:         pc_q,
            pc4:        seq_pc,
            pred_taken: pred_taken
          };
        end
      end
      HALT: begin
        if_d = IF_ID_BUBBLE;
      end
      default: begin
        state_d = HALT;
        if_d    = IF_ID_BUBBLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= BOOT;
      pc_q    <= align_word(RESET_ADDR);
      if_q    <= IF_ID_BUBBLE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_q    <= if_d;
    end
  end

  assign o_imem_raddr    = pc_q;
  assign o_if_valid      = if_q.valid;
  assign o_if_inst       = if_q.inst;
  assign o_if_pc         = if_q.pc;
  assign o_if_pc4        = if_q.pc4;
  assign o_if_pred_taken = if_q.pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model pushes expected IF/ID
// contents into a scoreboard queue each cycle; they are popped after the edge.
module tb_fetch_stage;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0100;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] BR_INST    = 32'hFE00_0EE3;  // beq x0,x0,-4
`ifdef FETCH_BTFN_EN
  localparam bit          BTFN       = 1'b1;
  localparam logic [31:0] BR_NEXT    = 32'h0000_001C;
`else
  localparam bit          BTFN       = 1'b0;
  localparam logic [31:0] BR_NEXT    = 32'h0000_0024;
`endif

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        pred;
    logic        chk_pc;
  } exp_t;

  localparam exp_t BUBBLE = '{1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0};

  logic        clk;
  logic        rst;
  logic [31:0] imem_raddr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_pred_taken;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [31:0] m_pc;
  logic        m_halted;
  exp_t        m_if;

  fetch_stage #(.RESET_ADDR(RESET_ADDR)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_raddr     (imem_raddr),
    .i_imem_rdata     (imem_rdata),
    .i_stall          (stall),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_halt           (halt),
    .o_if_valid       (if_valid),
    .o_if_inst        (if_inst),
    .o_if_pc          (if_pc),
    .o_if_pc4         (if_pc4),
    .o_if_pred_taken  (if_pred_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one backward branch at 0x20, address-tagged addi elsewhere.
  function automatic logic [31:0] imem_model(input logic [31:0] addr);
    if (addr == 32'h20) return BR_INST;
    return {addr[26:2], 7'b0010011};
  endfunction

  assign imem_rdata = imem_model(imem_raddr);

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock of stimulus; the model predicts PC and IF/ID for the coming edge.
  task automatic step(input logic r, input logic st, input logic rv,
                      input logic [31:0] rp, input logic hl);
    logic [31:0] inst;
    logic [31:0] tgt;
    logic [12:0] imm;
    logic        pr;
    exp_t        e;
    @(negedge clk);
    rst = r; stall = st; redirect_valid = rv; redirect_pc = rp; halt = hl;
    #1;
    check("raddr", imem_raddr, m_pc);
    inst = imem_model(m_pc);
    if (r) begin
      m_pc = RESET_ADDR; m_halted = 1'b0;
      m_if = '{1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b1};
    end else if (m_halted || hl) begin
      m_halted = 1'b1; m_if = BUBBLE;
    end else if (rv) begin
      m_pc = {rp[31:2], 2'b00}; m_if = BUBBLE;
    end else if (!st) begin
      pr   = BTFN && (inst[6:0] == 7'h63) && inst[31];
      imm  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      m_if = '{1'b1, inst, m_pc, m_pc + 32'd4, pr, 1'b1};
      tgt  = pr ? m_pc + {{19{imm[12]}}, imm} : m_pc + 32'd4;
      m_pc = {tgt[31:2], 2'b00};
    end
    sb.push_back(m_if);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("if_valid", {31'b0, if_valid}, {31'b0, e.valid});
      check("if_inst", if_inst, e.inst);
      check("if_pred", {31'b0, if_pred_taken}, {31'b0, e.pred});
      if (e.chk_pc) begin
        check("if_pc", if_pc, e.pc);
        check("if_pc4", if_pc4, e.pc4);
      end
    end
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic redirect(input logic [31:0] target, input logic st);
    step(1'b0, st, 1'b1, target, 1'b0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    repeat (2) @(posedge clk);
    m_pc = RESET_ADDR; m_halted = 1'b0; m_if = BUBBLE;

    // Reset values, then the first fetches from RESET_ADDR.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    advance(2);
    // Two stall cycles at 0x108, then fetching resumes.
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    advance(2);
    check("resume_raddr", imem_raddr, 32'h110);

    // Redirect beats a simultaneous stall.
    redirect(32'h200, 1'b1);
    check("redir_raddr", imem_raddr, 32'h200);
    advance(1);
    // Misaligned redirect is forced onto a word boundary.
    redirect(32'h303, 1'b0);
    check("align_raddr", imem_raddr, 32'h300);
    advance(1);

    // Backward branch at 0x20.
    redirect(32'h1C, 1'b0);
    advance(2);
    check("branch_next", imem_raddr, BR_NEXT);
    advance(2);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC, 1'b0);
    advance(1);
    check("wrap_pc4", if_pc4, 32'h0);
    check("wrap_raddr", imem_raddr, 32'h0);
    advance(1);

    // Random mix of advance / stall / redirect.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        1:       redirect({22'h0, $urandom_range(0, 255), 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)));
        default: advance(1);
      endcase
    end

    // Halt wins over a same-cycle redirect; later stimulus is ignored.
    redirect(32'h40, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h500, 1'b1);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h600, 1'b0);
    check("halt_raddr", imem_raddr, 32'h40);

    // Reset out of HALT restores the boot address.
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    advance(3);
    check("post_reset_raddr", imem_raddr, RESET_ADDR + 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
